// File: rtl/cdb_out_queue_if.sv
// Bundle of the producer-side CDB queue signals: execution-unit push, arbiter request/grant, status.
// "slave" is the queue's view; "master" is the view of the unit/arbiter environment around it.
interface cdb_out_queue_if #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4,
  parameter int unsigned DEPTH         = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic                     flush;
  logic                     push_valid;
  logic [CDB_TAG_WIDTH-1:0] push_tag;
  logic [DATA_WIDTH-1:0]    push_data;
  logic                     push_ready;
  logic                     cdb_out_request;
  logic [CDB_TAG_WIDTH-1:0] cdb_out_tag;
  logic [DATA_WIDTH-1:0]    cdb_out_data;
  logic                     cdb_out_accepted;
  logic [CntW-1:0]          count;
  logic                     overflow_error;

  modport master (
    output flush, push_valid, push_tag, push_data, cdb_out_accepted,
    input  push_ready, cdb_out_request, cdb_out_tag, cdb_out_data, count, overflow_error
  );

  modport slave (
    input  flush, push_valid, push_tag, push_data, cdb_out_accepted,
    output push_ready, cdb_out_request, cdb_out_tag, cdb_out_data, count, overflow_error
  );
endinterface

// File: rtl/cdb_out_queue.sv
// FIFO of (tag, data) results that requests the CDB and broadcasts its head on grant.
// Define CDB_OUT_QUEUE_BYPASS_EN to let an empty queue forward a push to the CDB in the same cycle.
module cdb_out_queue #(
  parameter int unsigned DATA_WIDTH    = 4,
  parameter int unsigned CDB_TAG_WIDTH = 4,
  parameter int unsigned DEPTH         = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  cdb_out_queue_if.slave bus
);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = CDB_TAG_WIDTH + DATA_WIDTH;

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic full, empty;
  logic push_ok, push_store, pop_store;
  logic [EntryW-1:0] head;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = bus.push_valid && !full && !bus.flush;

`ifdef CDB_OUT_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty && bus.push_valid && !bus.flush;

  // A bypassed entry that is granted immediately never touches storage.
  assign push_store = push_ok && !(bypass && bus.cdb_out_accepted);
  assign pop_store  = !empty && bus.cdb_out_accepted && !bus.flush;

  always_comb begin
    bus.cdb_out_request = !empty || bypass;
    bus.cdb_out_tag     = '0;
    bus.cdb_out_data    = '0;
    if (!empty) begin
      bus.cdb_out_tag  = head[EntryW-1:DATA_WIDTH];
      bus.cdb_out_data = head[DATA_WIDTH-1:0];
    end else if (bypass) begin
      bus.cdb_out_tag  = bus.push_tag;
      bus.cdb_out_data = bus.push_data;
    end
  end
`else
  assign push_store = push_ok;
  assign pop_store  = !empty && bus.cdb_out_accepted && !bus.flush;

  always_comb begin
    bus.cdb_out_request = !empty;
    bus.cdb_out_tag     = '0;
    bus.cdb_out_data    = '0;
    if (!empty) begin
      bus.cdb_out_tag  = head[EntryW-1:DATA_WIDTH];
      bus.cdb_out_data = head[DATA_WIDTH-1:0];
    end
  end
`endif

  assign bus.push_ready     = !full;
  assign bus.count          = count_q;
  assign bus.overflow_error = overflow_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // A push refused for lack of space is sticky; a flushed push is not an attempt.
    if (bus.push_valid && full && !bus.flush) begin
      overflow_d = 1'b1;
    end
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_store) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_store)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_store && !pop_store) begin
        count_d = count_q + 1'b1;
      end else if (pop_store && !push_store) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_store) begin
      mem_q[wr_ptr_q] <= {bus.push_tag, bus.push_data};
    end
  end
endmodule

// File: tb/tb_cdb_out_queue.sv
// Directed bench for cdb_out_queue with hand-computed expectations; follows the bypass macro.
module tb_cdb_out_queue;
  localparam int unsigned DW = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned D  = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  cdb_out_queue_if #(.DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .DEPTH(D)) bus ();

  cdb_out_queue #(.DATA_WIDTH(DW), .CDB_TAG_WIDTH(TW), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush            = 1'b0;
    bus.push_valid       = 1'b0;
    bus.cdb_out_accepted = 1'b0;
  endtask

  task automatic push(input logic [3:0] t, input logic [3:0] d);
    bus.push_valid = 1'b1;
    bus.push_tag   = t;
    bus.push_data  = d;
    tick();
    bus.push_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    bus.push_tag  = 4'h5;
    bus.push_data = 4'h5;

    // 1: reset with push_valid asserted
    rst_n          = 1'b0;
    bus.push_valid = 1'b1;
    tick();
    tick();
    rst_n          = 1'b1;
    bus.push_valid = 1'b0;
    #1;
    check("rst_request", bus.cdb_out_request, 0);
    check("rst_tag", bus.cdb_out_tag, 0);
    check("rst_data", bus.cdb_out_data, 0);
    check("rst_count", bus.count, 0);
    check("rst_push_ready", bus.push_ready, 1);
    check("rst_overflow", bus.overflow_error, 0);

    // 2: single entry held until granted
    push(4'h3, 4'hA);
    check("t2_request", bus.cdb_out_request, 1);
    check("t2_tag", bus.cdb_out_tag, 3);
    check("t2_data", bus.cdb_out_data, 4'hA);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_req", bus.cdb_out_request, 1);
      check("t2_hold_tag", bus.cdb_out_tag, 3);
    end
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    check("t2_pop_request", bus.cdb_out_request, 0);
    check("t2_pop_count", bus.count, 0);
    check("t2_pop_tag", bus.cdb_out_tag, 0);

    // 3: fill (pointers wrap), overflow, drain in order
    for (int i = 1; i <= 4; i++) push(4'(i), 4'(i + 8));
    check("t3_full_count", bus.count, 4);
    check("t3_full_ready", bus.push_ready, 0);
    check("t3_no_ovf_yet", bus.overflow_error, 0);
    push(4'h5, 4'h1);
    check("t3_ovf", bus.overflow_error, 1);
    check("t3_ovf_count", bus.count, 4);
    bus.cdb_out_accepted = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_drain_tag", bus.cdb_out_tag, i);
      check("t3_drain_data", bus.cdb_out_data, i + 8);
      tick();
    end
    bus.cdb_out_accepted = 1'b0;
    check("t3_empty_req", bus.cdb_out_request, 0);
    check("t3_ovf_sticky", bus.overflow_error, 1);

    // 4: simultaneous push+pop, then full+accept refuses push
    push(4'h1, 4'h1);
    push(4'h2, 4'h2);
    bus.cdb_out_accepted = 1'b1;
    push(4'h6, 4'h6);
    bus.cdb_out_accepted = 1'b0;
    check("t4_pp_count", bus.count, 2);
    check("t4_pp_head", bus.cdb_out_tag, 2);
    push(4'h7, 4'h7);
    push(4'h8, 4'h8);
    check("t4_full_ready", bus.push_ready, 0);
    bus.cdb_out_accepted = 1'b1;
    push(4'h9, 4'h9);
    bus.cdb_out_accepted = 1'b0;
    check("t4_fa_count", bus.count, 3);
    check("t4_fa_head", bus.cdb_out_tag, 6);
    check("t4_fa_ready", bus.push_ready, 1);

    // 5: flush beats same-cycle push and grant
    bus.flush            = 1'b1;
    bus.cdb_out_accepted = 1'b1;
    push(4'hA, 4'hA);
    idle();
    check("t5_count", bus.count, 0);
    check("t5_request", bus.cdb_out_request, 0);
    check("t5_tag", bus.cdb_out_tag, 0);
    check("t5_ovf_kept", bus.overflow_error, 1);
    push(4'h9, 4'h3);
    check("t5_first_tag", bus.cdb_out_tag, 9);
    check("t5_first_data", bus.cdb_out_data, 3);
    check("t5_first_count", bus.count, 1);
    bus.cdb_out_accepted = 1'b1;
    tick();
    bus.cdb_out_accepted = 1'b0;
    check("t5_drained", bus.count, 0);

    // 6: push into empty queue with grant asserted
    bus.push_valid       = 1'b1;
    bus.push_tag         = 4'h7;
    bus.push_data        = 4'h5;
    bus.cdb_out_accepted = 1'b1;
    #1;
`ifdef CDB_OUT_QUEUE_BYPASS_EN
    check("t6_byp_req", bus.cdb_out_request, 1);
    check("t6_byp_tag", bus.cdb_out_tag, 7);
    check("t6_byp_data", bus.cdb_out_data, 5);
    tick();
    idle();
    check("t6_byp_count", bus.count, 0);
    check("t6_byp_req_after", bus.cdb_out_request, 0);
`else
    check("t6_req_same", bus.cdb_out_request, 0);
    tick();
    idle();
    check("t6_req_next", bus.cdb_out_request, 1);
    check("t6_tag_next", bus.cdb_out_tag, 7);
    check("t6_data_next", bus.cdb_out_data, 5);
    check("t6_count_next", bus.count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
